// File: rtl/force_release_target_pkg.sv
// force_pkg: request opcodes and FSM states shared by the override unit.
package force_pkg;
  typedef enum logic [1:0] {OP_NOP, OP_FORCE, OP_FORCE_TIMED, OP_RELEASE} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_FORCED, ST_TIMED, ST_RELEASING} state_e;
endpackage

// File: rtl/force_release_target_hold_timer.sv
// hold_timer: down-counter for timed forces; a zero load acts as one and the count never wraps.
module hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             expire
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? (value == '0 ? CNT_W'(1) : value)
                 : ((dec && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
  assign expire = cnt_q == CNT_W'(1);
endmodule

// File: rtl/force_release_target.sv
// force_release_target: registered pass-through of func_d that can be overridden
// by a held or timed forced value via a valid/ready request port.
module force_release_target
  import force_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] func_d,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_val,
  input  logic [CNT_W-1:0] req_hold,
  output logic [WIDTH-1:0] q,
  output logic             forced,
  output logic             rel_pulse,
  output logic             err
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ready_q, err_q, err_d;
  logic             accept, act, load, dec, expire, forced_d;
  op_e              op;
  assign op     = op_e'(req_op);
  assign accept = req_valid & req_ready;
  assign act    = accept & (op != OP_NOP);
  assign load   = accept & (op == OP_FORCE_TIMED);
  assign dec    = (state_q == ST_TIMED) & ~act;
  hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .load   (load),
    .value  (req_hold),
    .dec    (dec),
    .expire (expire)
  );
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (state_q == ST_RELEASING) state_d = ST_IDLE;
    else if (act)
      case (op)
        OP_FORCE:       state_d = ST_FORCED;
        OP_FORCE_TIMED: state_d = ST_TIMED;
        OP_RELEASE: begin
          state_d = state_q == ST_IDLE ? ST_IDLE : ST_RELEASING;
          err_d   = state_q == ST_IDLE;
        end
        default: state_d = state_q;
      endcase
    else if (state_q == ST_TIMED && expire) state_d = ST_RELEASING;
    forced_d = (state_d == ST_FORCED) || (state_d == ST_TIMED);
    q_d      = forced_d ? (act ? req_val : q_q) : func_d;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      err_q   <= err_d;
      ready_q <= 1'b1;
    end
  end
  assign req_ready = ready_q & (state_q != ST_RELEASING);
  assign forced    = (state_q == ST_FORCED) || (state_q == ST_TIMED);
  assign rel_pulse = state_q == ST_RELEASING;
  assign err       = err_q;
  assign q         = q_q;
endmodule

// File: tb/tb_force_release_target.sv
// tb_force_release_target: directed plus random requests checked against a
// cycle-level model of the override rules.
module tb_force_release_target;
  logic       clk = 1'b0;
  logic       rstn, req_valid, req_ready, forced, rel_pulse, err;
  logic [1:0] req_op;
  logic [7:0] func_d, req_val, req_hold, q;
  int vectors = 0, miscompares = 0;
  bit   m_forced, m_rel, m_err, m_ready_en;
  int   m_left;
  logic [7:0] m_q;

  force_release_target #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .func_d(func_d), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_val(req_val), .req_hold(req_hold), .q(q), .forced(forced),
    .rel_pulse(rel_pulse), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q = 8'h00; m_forced = 0; m_rel = 0; m_err = 0; m_ready_en = 0; m_left = -1;
  endtask

  // m_left: remaining forced cycles of a timed force, -1 when held until release
  task automatic model_edge();
    bit acc, new_err;
    if (!rstn) begin model_reset(); return; end
    acc = req_valid && m_ready_en && !m_rel;
    new_err = 0;
    if (m_rel) begin m_rel = 0; m_q = func_d; end
    else if (acc && req_op == 2'd1) begin m_forced = 1; m_left = -1; m_q = req_val; end
    else if (acc && req_op == 2'd2) begin
      m_forced = 1; m_left = (req_hold == 0) ? 1 : int'(req_hold); m_q = req_val;
    end
    else if (acc && req_op == 2'd3) begin
      if (m_forced) begin m_forced = 0; m_rel = 1; end else new_err = 1;
      m_q = func_d;
    end
    else if (m_forced) begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_forced = 0; m_rel = 1; m_q = func_d; end
      end
    end
    else m_q = func_d;
    m_err = new_err;
    m_ready_en = 1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, q, m_q);
    chk({tag, ".forced"}, {7'd0, forced}, {7'd0, m_forced});
    chk({tag, ".rel_pulse"}, {7'd0, rel_pulse}, {7'd0, m_rel});
    chk({tag, ".err"}, {7'd0, err}, {7'd0, m_err});
    chk({tag, ".req_ready"}, {7'd0, req_ready}, {7'd0, m_ready_en && !m_rel});
  endtask

  task automatic cyc(input string tag, input logic v, input logic [1:0] op,
                     input logic [7:0] val, input logic [7:0] hold, input logic [7:0] fd);
    req_valid = v; req_op = op; req_val = val; req_hold = hold; func_d = fd;
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  task automatic nop(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 2'd0, 8'h00, 8'h00, 8'($urandom));
  endtask

  initial begin
    rstn = 1'b0; req_valid = 0; req_op = 0; req_val = 0; req_hold = 0; func_d = 8'hA5;
    model_reset();
    #1 check_all("reset");
    cyc("reset_hold", 0, 0, 0, 0, 8'hA5);
    cyc("reset_hold", 0, 0, 0, 0, 8'hA5);
    rstn = 1'b1;
    cyc("pass_a5", 0, 0, 0, 0, 8'hA5);
    cyc("pass_3c", 0, 0, 0, 0, 8'h3C);
    cyc("pass_3c2", 0, 0, 0, 0, 8'h3C);
    cyc("force_01", 1, 2'd1, 8'h01, 0, 8'h55);
    cyc("force_hold", 0, 0, 0, 0, 8'hAA);
    cyc("force_hold", 0, 0, 0, 0, 8'h55);
    cyc("release", 1, 2'd3, 0, 0, 8'h66);
    cyc("releasing_blk", 1, 2'd1, 8'h09, 0, 8'h77);
    nop("after_rel", 2);
    cyc("timed_h5", 1, 2'd2, 8'h11, 8'd5, 8'h20);
    nop("timed_h5_run", 7);
    cyc("timed_h0", 1, 2'd2, 8'h22, 8'd0, 8'h30);
    nop("timed_h0_run", 3);
    cyc("retarget_a", 1, 2'd1, 8'h01, 0, 8'h40);
    cyc("retarget_b", 1, 2'd1, 8'h03, 0, 8'h41);
    nop("retarget_hold", 1);
    cyc("retarget_rel", 1, 2'd3, 0, 0, 8'h42);
    nop("retarget_after", 2);
    cyc("reload_a", 1, 2'd2, 8'h05, 8'd4, 8'h50);
    nop("reload_run", 2);
    cyc("reload_b", 1, 2'd2, 8'h07, 8'd3, 8'h51);
    nop("reload_run2", 5);
    cyc("err_idle", 1, 2'd3, 0, 0, 8'h60);
    nop("err_after", 2);
    cyc("exp_force_a", 1, 2'd2, 8'h44, 8'd2, 8'h61);
    nop("exp_force_run", 1);
    cyc("exp_force_hit", 1, 2'd1, 8'h45, 0, 8'h62);
    nop("exp_force_hold", 2);
    cyc("exp_force_rel", 1, 2'd3, 0, 0, 8'h63);
    nop("exp_force_after", 2);
    cyc("exp_rel_a", 1, 2'd2, 8'h46, 8'd2, 8'h64);
    nop("exp_rel_run", 1);
    cyc("exp_rel_hit", 1, 2'd3, 0, 0, 8'h65);
    nop("exp_rel_after", 2);
    cyc("rst_mid_a", 1, 2'd2, 8'h66, 8'd5, 8'h70);
    nop("rst_mid_run", 1);
    rstn = 1'b0;
    model_reset();
    #1 check_all("rst_mid");
    nop("rst_mid_hold", 1);
    rstn = 1'b1;
    nop("rst_mid_after", 2);
    cyc("rst_mid_force", 1, 2'd1, 8'h77, 0, 8'h71);
    cyc("rst_mid_rel", 1, 2'd3, 0, 0, 8'h72);
    nop("rst_mid_end", 2);
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      cyc("rand", 1'($urandom_range(0, 2) != 0), op, 8'($urandom), 8'($urandom_range(0, 6)),
          8'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/force_release_target.md
# force_release_target

Target-side override unit for debug and verification. It accepts force and release requests over a valid/ready handshake and drives a registered output. The output carries either the functional value or a forced value, either held until an explicit release or for a programmed number of cycles. It sits between a functional source and its consumers, and is driven by the debug/override controller.

## Interface
- WIDTH, 8, width of functional, forced and output data
- CNT_W, 8, width of the hold-cycle counter for timed forces

- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- func_d  in  WIDTH  functional value, passed through when not forced
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_op  in  2  00 NOP, 01 FORCE, 10 FORCE_TIMED, 11 RELEASE
- req_val  in  WIDTH  value to force (FORCE/FORCE_TIMED)
- req_hold  in  CNT_W  hold cycles for FORCE_TIMED
- q  out  WIDTH  registered output
- forced  out  1  override active
- rel_pulse  out  1  one-cycle pulse when an override ends
- err  out  1  one-cycle pulse on a RELEASE while not forced

## Operation
- One clock; reset is asynchronous and active-low.
- Accept = req_valid & req_ready at a rising edge. NOP accepted, no effect.
- States:
  - IDLE: q <= func_d every cycle.
  - FORCED: q holds the forced value until RELEASE.
  - TIMED: q holds the forced value while the hold counter runs.
  - RELEASING: one cycle.
- IDLE transitions:
  - FORCE -> FORCED, q <= req_val.
  - FORCE_TIMED -> TIMED, q <= req_val, cnt <= max(req_hold,1).
  - RELEASE -> stay IDLE, err=1 for one cycle.
- FORCED/TIMED transitions:
  - FORCE -> FORCED, q <= req_val (retarget; timer discarded).
  - FORCE_TIMED -> TIMED, q <= req_val, cnt reloaded.
  - RELEASE -> RELEASING.
- TIMED: cnt decrements each cycle with no accepted non-NOP request. An edge with cnt==1 -> RELEASING.
- RELEASING: q <= func_d, forced=0, rel_pulse=1, req_ready=0; next edge -> IDLE.
- forced=1 exactly in FORCED and TIMED.
- req_ready=1 in IDLE/FORCED/TIMED, 0 in RELEASING and while rstn low.

## Timing
- Reset values: q=0, forced=0, rel_pulse=0, err=0, req_ready=0 (asserted first cycle after rstn deasserts), state IDLE, cnt=0.
- Pass-through latency: func_d to q is 1 cycle.
- Force latency: FORCE accepted at edge N -> q=req_val, forced=1 from N until the next edge.
- Timed hold: FORCE_TIMED with H accepted at edge N -> q forced for H cycles, RELEASING entered at edge N+H, IDLE at N+H+1. req_hold=0 behaves as 1.
- Release: RELEASE accepted at edge N -> RELEASING at N; q=func_d sampled at N; rel_pulse high for cycle N..N+1.
- Simultaneous events: an accepted request at the timer-expiry edge wins over the expiry. FORCE wins (retarget/reload); RELEASE gives the same result as expiry.
- Reset mid-operation: immediate return to reset values, no rel_pulse.
- Width rules: cnt is unsigned CNT_W and never wraps (stops at expiry). q is exactly WIDTH; no truncation.

## Structure
- Package force_pkg holds:
  - op_e (OP_NOP, OP_FORCE, OP_FORCE_TIMED, OP_RELEASE)
  - state_e (ST_IDLE, ST_FORCED, ST_TIMED, ST_RELEASING)
- One sub-module: hold_timer, with load/value/decrement/expire, CNT_W parameter.
- FSM, output mux and pulse logic live in the top module.

## Test plan
- Reset/pass-through: rstn low with func_d=8'hA5 -> q=0, req_ready=0. Release rstn -> q=8'hA5 one cycle later; change func_d to 8'h3C -> q follows after 1 cycle.
- Force/release: FORCE 8'h01 while func_d toggles -> q stays 8'h01, forced=1. RELEASE -> one rel_pulse, req_ready low 1 cycle, q=func_d.
- Timed force: FORCE_TIMED 8'h11 with H=5 -> q=8'h11 for exactly 5 cycles, then rel_pulse, then pass-through. H=0 -> 1 cycle.
- Retarget: FORCE 8'h01, then FORCE 8'h03 -> q=8'h03, no rel_pulse. FORCE_TIMED H=4, then FORCE_TIMED 8'h07 H=3 on the 3rd cycle -> 3 more forced cycles.
- Collisions/errors: RELEASE in IDLE -> err one cycle, q unchanged path. FORCE at the timer-expiry edge -> stays forced, no rel_pulse.
- Reset mid-force: assert rstn low during TIMED -> q=0, forced=0, no rel_pulse; normal operation afterwards.
